ternary_mvm_engine: RTL and testbench

TERNARY_MVM_ENGINE -- requirements
Module: ternary_mvm_engine

---
 rtl/ternary_mvm_engine_pkg.sv | 24 ++
 rtl/ternary_mvm_engine_if.sv | 34 +++
 rtl/ternary_mvm_engine_row_mac.sv | 63 ++++++
 rtl/ternary_mvm_engine.sv | 164 ++++++++++++++++
 tb/tb_ternary_mvm_engine.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ternary_mvm_engine_pkg.sv
// Shared constants, FSM encoding and width helpers for the ternary matrix-vector engine.
package ternary_pkg;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Sum of in_len signed act_w-bit terms of magnitude up to 2^(act_w-1) never overflows this width.
  function automatic int acc_width(input int in_len, input int act_w);
    return act_w + $clog2(in_len) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ternary_mvm_engine_if.sv
// Weight, activation and result handshakes plus status flags of the ternary MVM engine.
interface ternary_mvm_engine_if
  import ternary_pkg::*;
#(
  parameter int IN_LEN = 12,
  parameter int ACT_W  = 8
);
  localparam int ACC_W = acc_width(IN_LEN, ACT_W);

  logic                     cfg_load;
  logic                     w_valid;
  logic                     w_ready;
  logic [2*IN_LEN-1:0]      w_data;
  logic                     x_valid;
  logic                     x_ready;
  logic signed [ACT_W-1:0]  x_data;
  logic                     y_valid;
  logic                     y_ready;
  logic signed [ACC_W-1:0]  y_data;
  logic                     y_last;
  logic                     w_loaded;
  logic                     busy;

  modport slave (
    input  cfg_load, w_valid, w_data, x_valid, x_data, y_ready,
    output w_ready, x_ready, y_valid, y_data, y_last, w_loaded, busy
  );

  modport master (
    output cfg_load, w_valid, w_data, x_valid, x_data, y_ready,
    input  w_ready, x_ready, y_valid, y_data, y_last, w_loaded, busy
  );

endinterface

// File: rtl/ternary_mvm_engine_row_mac.sv
// One weight row: holds its 2-bit codes and accumulates code[idx] * x for each accepted element.
module ternary_row_mac
  import ternary_pkg::*;
#(
  parameter int IN_LEN = 12,
  parameter int ACT_W  = 8,
  parameter int ACC_W  = 13,
  parameter int IW     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_we_i,
  input  logic [2*IN_LEN-1:0]     w_row_i,
  input  logic                    x_en_i,
  input  logic [IW-1:0]           idx_i,
  input  logic                    first_i,
  input  logic signed [ACT_W-1:0] x_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic [2*IN_LEN-1:0]     w_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [1:0]              code_s;
  logic signed [ACC_W-1:0] xe_s, term_s;

  // Select the current column's code and form the signed product term.
  always_comb begin
    code_s = w_q[{idx_i, 1'b0} +: 2];
    xe_s   = {{(ACC_W-ACT_W){x_i[ACT_W-1]}}, x_i};
    case (code_s)
      W_POS:   term_s = xe_s;
      W_NEG:   term_s = -xe_s;
      default: term_s = '0;
    endcase
    // The first element overwrites, so a new vector needs no clear cycle.
    if (first_i) begin
      acc_d = term_s;
    end else begin
      acc_d = acc_q + term_s;
    end
  end

  // Weight row register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (w_we_i) begin
      w_q <= w_row_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (x_en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ternary_mvm_engine.sv
// Ternary-weight matrix-vector engine: load OUT_LEN weight rows, stream IN_LEN activations, drain OUT_LEN results.
// Optional macro TERNARY_MVM_RELU_EN clamps negative results to zero on y_data.
module ternary_mvm_engine
  import ternary_pkg::*;
#(
  parameter int IN_LEN  = 12,
  parameter int OUT_LEN = 12,
  parameter int ACT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ternary_mvm_engine_if.slave  bus
);

  localparam int ACC_W = acc_width(IN_LEN, ACT_W);
  localparam int EW    = cnt_width(IN_LEN);
  localparam int RW    = cnt_width(OUT_LEN);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] LOAD  = ST_LOAD;
  localparam logic [1:0] ACCUM = ST_ACCUM;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  logic [1:0]              state_q, state_d;
  logic [RW-1:0]           row_q, row_d, out_q, out_d;
  logic [EW-1:0]           elem_q, elem_d;
  logic                    w_loaded_q, w_loaded_d;
  logic                    x_hs_s, w_hs_s, first_s;
  logic [EW-1:0]           idx_s;
  logic signed [ACC_W-1:0] acc_s [OUT_LEN];
  logic signed [ACC_W-1:0] y_sel_s;

  assign bus.w_ready  = (state_q == LOAD);
  assign bus.x_ready  = ((state_q == IDLE) && w_loaded_q && !bus.cfg_load) || (state_q == ACCUM);
  assign bus.y_valid  = (state_q == DRAIN);
  assign bus.y_last   = (state_q == DRAIN) && (out_q == RW'(OUT_LEN - 1));
  assign bus.busy     = (state_q != IDLE);
  assign bus.w_loaded = w_loaded_q;

  assign x_hs_s  = bus.x_valid && bus.x_ready;
  assign w_hs_s  = bus.w_valid && bus.w_ready;
  assign first_s = (state_q == IDLE);
  assign idx_s   = first_s ? '0 : elem_q;

  for (genvar r = 0; r < OUT_LEN; r++) begin : g_row
    ternary_row_mac #(
      .IN_LEN (IN_LEN),
      .ACT_W  (ACT_W),
      .ACC_W  (ACC_W),
      .IW     (EW)
    ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .w_we_i  (w_hs_s && (row_q == RW'(r))),
      .w_row_i (bus.w_data),
      .x_en_i  (x_hs_s),
      .idx_i   (idx_s),
      .first_i (first_s),
      .x_i     (bus.x_data),
      .acc_o   (acc_s[r])
    );
  end

  // Result mux with optional rectification.
  always_comb begin
    y_sel_s = acc_s[out_q];
`ifdef TERNARY_MVM_RELU_EN
    if (y_sel_s[ACC_W-1]) begin
      bus.y_data = '0;
    end else begin
      bus.y_data = y_sel_s;
    end
`else
    bus.y_data = y_sel_s;
`endif
  end

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    out_d      = out_q;
    elem_d     = elem_q;
    w_loaded_d = w_loaded_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_load) begin
          state_d    = LOAD;
          row_d      = '0;
          w_loaded_d = 1'b0;
        end else if (x_hs_s) begin
          out_d = '0;
          if (IN_LEN == 1) begin
            state_d = DRAIN;
            elem_d  = '0;
          end else begin
            state_d = ACCUM;
            elem_d  = EW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (w_hs_s) begin
          if (row_q == RW'(OUT_LEN - 1)) begin
            state_d    = IDLE;
            row_d      = '0;
            w_loaded_d = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      ACCUM: begin
        if (x_hs_s) begin
          if (elem_q == EW'(IN_LEN - 1)) begin
            state_d = DRAIN;
            elem_d  = '0;
          end else begin
            elem_d = elem_q + EW'(1);
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        if (bus.y_ready) begin
          if (out_q == RW'(OUT_LEN - 1)) begin
            state_d = IDLE;
            out_d   = '0;
          end else begin
            out_d = out_q + RW'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      out_q      <= '0;
      elem_q     <= '0;
      w_loaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      out_q      <= out_d;
      elem_q     <= elem_d;
      w_loaded_q <= w_loaded_d;
    end
  end

endmodule

// File: tb/tb_ternary_mvm_engine.sv
// Directed bench: small 3x2 engine for handshake/function/reset cases, 12-column engine for full-scale accumulation.
module tb_ternary_mvm_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef TERNARY_MVM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  always #5 clk = ~clk;

  ternary_mvm_engine_if #(.IN_LEN(3),  .ACT_W(8)) ifa ();
  ternary_mvm_engine_if #(.IN_LEN(12), .ACT_W(8)) ifb ();

  ternary_mvm_engine #(.IN_LEN(3), .OUT_LEN(2), .ACT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  ternary_mvm_engine #(.IN_LEN(12), .OUT_LEN(4), .ACT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  function automatic logic signed [31:0] relu(input logic signed [31:0] v);
    return (RELU && v < 0) ? 32'sd0 : v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rows_a(input logic [5:0] r0, input logic [5:0] r1);
    logic [5:0] rows [2];
    rows[0] = r0;
    rows[1] = r1;
    for (int r = 0; r < 2; r++) begin
      int n = 0;
      ifa.w_data  = rows[r];
      ifa.w_valid = 1'b1;
      while (!ifa.w_ready && n < 20) begin @(negedge clk); n++; end
      chk("w_ready_wait", 32'(n < 20), 32'sd1);
      @(posedge clk); #1;
    end
    ifa.w_valid = 1'b0;
  endtask

  task automatic load_a(input logic [5:0] r0, input logic [5:0] r1);
    ifa.cfg_load = 1'b1;
    @(posedge clk); #1;
    ifa.cfg_load = 1'b0;
    rows_a(r0, r1);
  endtask

  task automatic send_a(input logic signed [7:0] v);
    int n = 0;
    ifa.x_data  = v;
    ifa.x_valid = 1'b1;
    while (!ifa.x_ready && n < 20) begin @(negedge clk); n++; end
    chk("x_ready_wait", 32'(n < 20), 32'sd1);
    @(posedge clk); #1;
    ifa.x_valid = 1'b0;
  endtask

  task automatic recv_a(input string tag, input logic signed [31:0] exp, input logic exp_last);
    int n = 0;
    while (!ifa.y_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_wait"}, 32'(n < 20), 32'sd1);
    chk({tag, "_data"}, ifa.y_data, exp);
    chk({tag, "_last"}, ifa.y_last, 32'(exp_last));
    @(posedge clk); #1;
  endtask

  initial begin
    ifa.cfg_load = 1'b0; ifa.w_valid = 1'b0; ifa.w_data = '0;
    ifa.x_valid = 1'b0; ifa.x_data = '0; ifa.y_ready = 1'b1;
    ifb.cfg_load = 1'b0; ifb.w_valid = 1'b0; ifb.w_data = '0;
    ifb.x_valid = 1'b0; ifb.x_data = '0; ifb.y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_busy",     ifa.busy,     32'sd0);
    chk("rst_w_loaded", ifa.w_loaded, 32'sd0);
    chk("rst_y_valid",  ifa.y_valid,  32'sd0);
    chk("rst_w_ready",  ifa.w_ready,  32'sd0);
    chk("rst_x_ready",  ifa.x_ready,  32'sd0);

    // Rows {+1,-1,0} and {-1,-1,+1}, column 0 in the LSBs.
    load_a(6'b00_11_01, 6'b01_11_11);
    chk("load_w_loaded", ifa.w_loaded, 32'sd1);
    chk("load_busy",     ifa.busy,     32'sd0);

    send_a(8'sd5);
    send_a(8'sd3);
    chk("no_early_y", ifa.y_valid, 32'sd0);
    send_a(-8'sd7);
    chk("latency_1", ifa.y_valid, 32'sd1);
    recv_a("v1_y0", relu(32'sd2), 1'b0);
    recv_a("v1_y1", relu(-32'sd15), 1'b1);
    chk("v1_idle", ifa.busy, 32'sd0);

    ifa.y_ready = 1'b0;
    send_a(-8'sd4);
    send_a(8'sd2);
    send_a(8'sd9);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", ifa.y_valid, 32'sd1);
      chk("stall_data",  ifa.y_data,  relu(-32'sd6));
      chk("stall_last",  ifa.y_last,  32'sd0);
    end
    ifa.y_ready = 1'b1;
    recv_a("v2_y0", relu(-32'sd6), 1'b0);
    recv_a("v2_y1", relu(32'sd11), 1'b1);

    send_a(-8'sd4);
    send_a(8'sd2);
    send_a(8'sd9);
    recv_a("v3_y0", relu(-32'sd6), 1'b0);
    recv_a("v3_y1", relu(32'sd11), 1'b1);

    // cfg_load beats x_valid in IDLE.
    ifa.cfg_load = 1'b1;
    ifa.x_valid  = 1'b1;
    ifa.x_data   = 8'sd1;
    #1;
    chk("race_x_ready", ifa.x_ready, 32'sd0);
    @(posedge clk); #1;
    ifa.cfg_load = 1'b0;
    ifa.x_valid  = 1'b0;
    chk("race_busy",     ifa.busy,     32'sd1);
    chk("race_w_ready",  ifa.w_ready,  32'sd1);
    chk("race_w_loaded", ifa.w_loaded, 32'sd0);
    rows_a(6'b00_11_01, 6'b01_11_11);
    chk("reload_w_loaded", ifa.w_loaded, 32'sd1);

    // Reset in the middle of a vector.
    send_a(8'sd5);
    send_a(8'sd3);
    chk("mid_busy", ifa.busy, 32'sd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",     ifa.busy,     32'sd0);
    chk("arst_w_loaded", ifa.w_loaded, 32'sd0);
    chk("arst_y_valid",  ifa.y_valid,  32'sd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ifa.x_valid = 1'b1;
    ifa.x_data  = -8'sd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_x_ready", ifa.x_ready, 32'sd0);
      chk("post_rst_y_valid", ifa.y_valid, 32'sd0);
    end
    ifa.x_valid = 1'b0;
    @(posedge clk); #1;

    // Full-scale 12-column engine: all weights +1, all x = -128.
    begin
      int n;
      ifb.cfg_load = 1'b1;
      @(posedge clk); #1;
      ifb.cfg_load = 1'b0;
      ifb.w_data = {12{2'b01}};
      for (int r = 0; r < 4; r++) begin
        n = 0;
        ifb.w_valid = 1'b1;
        while (!ifb.w_ready && n < 20) begin @(negedge clk); n++; end
        chk("b_w_ready_wait", 32'(n < 20), 32'sd1);
        @(posedge clk); #1;
      end
      ifb.w_valid = 1'b0;
      chk("b_w_loaded", ifb.w_loaded, 32'sd1);
      ifb.x_data = -8'sd128;
      for (int i = 0; i < 12; i++) begin
        n = 0;
        ifb.x_valid = 1'b1;
        while (!ifb.x_ready && n < 20) begin @(negedge clk); n++; end
        chk("b_x_ready_wait", 32'(n < 20), 32'sd1);
        @(posedge clk); #1;
      end
      ifb.x_valid = 1'b0;
      for (int r = 0; r < 4; r++) begin
        n = 0;
        while (!ifb.y_valid && n < 20) begin @(negedge clk); n++; end
        chk("b_y_wait", 32'(n < 20), 32'sd1);
        chk("b_y_data", ifb.y_data, relu(-32'sd1536));
        chk("b_y_last", ifb.y_last, 32'((r == 3) ? 1 : 0));
        @(posedge clk); #1;
      end
      chk("b_idle", ifb.busy, 32'sd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
